// File: rtl/image_pipe_arb_pkg.sv
// image_pipe_arb_pkg: shared types for the image pipe input arbiter.
// Holds the FSM state enum, the source index type and the last_grant reset value.
package image_pipe_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef logic src_t;

    // last_grant resets to source 1 so source 0 wins the first tie
    localparam src_t LAST_GRANT_RST = 1'b1;

endpackage

// File: rtl/image_pipe_arb_rr.sv
// image_pipe_arb_rr: 2-way round-robin pick.
// Ports: i_req (per-source request), i_last_grant -> o_any (any request), o_grant (winner).
module image_pipe_arb_rr
    import image_pipe_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  src_t       i_last_grant,
    output logic       o_any,
    output src_t       o_grant
);

    always_comb begin
        o_any   = |i_req;
        o_grant = 1'b0;
        if (&i_req) begin
            // tie: the source that did not win last time
            o_grant = ~i_last_grant;
        end else begin
            o_grant = i_req[1];
        end
    end

endmodule

// File: rtl/image_pipe_arb.sv
// image_pipe_arb: frame-granular round-robin arbiter for the image pipe input.
// Ports: clk/rst, in0_*/in1_* sources, cfg_enable, out_* toward pipe, frame_cnt0/1.
// Macro IMAGE_PIPE_ARB_GAP_EN adds GAP_CYC blanking cycles after each frame.
module image_pipe_arb
    import image_pipe_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int GAP_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    output logic              in0_busy,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              in1_busy,
    input  logic [1:0]        cfg_enable,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src,
    input  logic              out_busy,
    output logic [CNT_W-1:0]  frame_cnt0,
    output logic [CNT_W-1:0]  frame_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t r_state;
    src_t   r_grant;
    src_t   r_last_grant;
`ifdef IMAGE_PIPE_ARB_GAP_EN
    logic [7:0] r_gap_cnt;
`endif

    logic              w_any;
    src_t              w_rr_grant;
    logic              w_xfer;
    logic              w_hold;
    logic              w_sel_valid;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_sel_last;
    logic              w_acc;
    logic              w_acc_last;

    image_pipe_arb_rr u_rr (
        .i_req        ({in1_valid & cfg_enable[1], in0_valid & cfg_enable[0]}),
        .i_last_grant (r_last_grant),
        .o_any        (w_any),
        .o_grant      (w_rr_grant)
    );

    // output register full and pipe stalled: nothing may load
    assign w_hold = out_valid & out_busy;
    assign w_xfer = (r_state == ST_XFER);

    assign in0_busy = !(w_xfer && (r_grant == 1'b0)) || w_hold;
    assign in1_busy = !(w_xfer && (r_grant == 1'b1)) || w_hold;

    assign w_sel_valid = r_grant ? in1_valid : in0_valid;
    assign w_sel_data  = r_grant ? in1_data  : in0_data;
    assign w_sel_last  = r_grant ? in1_last  : in0_last;

    assign w_acc      = w_xfer & w_sel_valid & ~w_hold;
    assign w_acc_last = w_acc & w_sel_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= LAST_GRANT_RST;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            out_src      <= 1'b0;
            frame_cnt0   <= '0;
            frame_cnt1   <= '0;
`ifdef IMAGE_PIPE_ARB_GAP_EN
            r_gap_cnt    <= '0;
`endif
        end else begin
            if (w_acc) begin
                out_valid <= 1'b1;
                out_data  <= w_sel_data;
                out_last  <= w_sel_last;
                out_src   <= r_grant;
            end else if (out_valid && !out_busy) begin
                out_valid <= 1'b0;
            end

            if (w_acc_last) begin
                if (r_grant) frame_cnt1 <= frame_cnt1 + CNT_ONE;
                else         frame_cnt0 <= frame_cnt0 + CNT_ONE;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_rr_grant;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_acc_last) begin
                        r_last_grant <= r_grant;
`ifdef IMAGE_PIPE_ARB_GAP_EN
                        r_state   <= ST_GAP;
                        r_gap_cnt <= 8'(GAP_CYC - 1);
`else
                        r_state   <= ST_IDLE;
`endif
                    end
                end
`ifdef IMAGE_PIPE_ARB_GAP_EN
                ST_GAP: begin
                    if (r_gap_cnt == 8'd0) r_state <= ST_IDLE;
                    else                   r_gap_cnt <= r_gap_cnt - 8'd1;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
